nm_mem_responder: RTL

NM_MEM_RESPONDER -- requirements
Module: nm_mem_responder

---
 rtl/nm_mem_responder.sv | 137 +++++++++++++
 1 files changed

// File: rtl/nm_mem_responder.sv
// nm_mem_responder: word memory that answers a held mem_sel request after LATENCY cycles with a one-cycle ready strobe.
// Optional macro NM_MEM_BOUNDS_CHECK_EN rejects addresses >= DEPTH and adds the sticky oob_err output.
module nm_mem_responder #(
    parameter int ADDR_WIDTH    = 16,
    parameter int DATABUS_WIDTH = 32,
    parameter int DEPTH         = 1024,
    parameter int LATENCY       = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     mem_sel,
    input  logic                     mem_w,
    input  logic [ADDR_WIDTH-1:0]    address_bus,
    inout  logic [DATABUS_WIDTH-1:0] data_bus,
    output logic                     ready,
    output logic                     busy
`ifdef NM_MEM_BOUNDS_CHECK_EN
    ,
    output logic                     oob_err
`endif
);

    localparam int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W  = 4;
    localparam int AEXT_W = ADDR_WIDTH + 1;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP,
        HOLDOFF
    } state_e;

    state_e                   state_q;
    logic [CNT_W-1:0]         cnt_q;
    logic [IDX_W-1:0]         idx_q;
    logic                     isWrite_q;
    logic [DATABUS_WIDTH-1:0] writeData_q;
    logic [DATABUS_WIDTH-1:0] readData_q;
    logic                     ready_q;
    logic                     busy_q;
    logic [DATABUS_WIDTH-1:0] mem_q [DEPTH];

    logic                     finish_d;
    logic                     drop_d;

    // The access commits on the same edge that raises ready, and only if the initiator still holds mem_sel.
    assign finish_d = (state_q == WAIT) && mem_sel && (cnt_q == '0);

`ifdef NM_MEM_BOUNDS_CHECK_EN
    logic reqOob_q;
    logic oob_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            reqOob_q <= 1'b0;
            oob_q    <= 1'b0;
        end else begin
            if (state_q == IDLE && mem_sel) begin
                reqOob_q <= ({1'b0, address_bus} >= AEXT_W'(DEPTH));
            end
            if (finish_d && reqOob_q) begin
                oob_q <= 1'b1;
            end
        end
    end

    assign drop_d  = reqOob_q;
    assign oob_err = oob_q;
`else
    logic unusedAddrBits;
    assign unusedAddrBits = ^address_bus;
    assign drop_d = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst && finish_d && isWrite_q && !drop_d) begin
            mem_q[idx_q] <= writeData_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            isWrite_q <= 1'b0;
            ready_q   <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            ready_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (mem_sel) begin
                        idx_q       <= address_bus[IDX_W-1:0];
                        isWrite_q   <= mem_w;
                        writeData_q <= data_bus;
                        cnt_q       <= CNT_W'(LATENCY - 1);
                        busy_q      <= 1'b1;
                        state_q     <= WAIT;
                    end
                end
                WAIT: begin
                    if (!mem_sel) begin
                        cnt_q   <= '0;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else if (cnt_q == '0) begin
                        readData_q <= drop_d ? '0 : mem_q[idx_q];
                        ready_q    <= 1'b1;
                        state_q    <= RESP;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                RESP: begin
                    state_q <= HOLDOFF;
                end
                HOLDOFF: begin
                    // A new request is only taken once the initiator has released mem_sel.
                    if (!mem_sel) begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign data_bus = (ready_q && !isWrite_q && !rst) ? readData_q : 'z;
    assign ready    = ready_q;
    assign busy     = busy_q;

endmodule
